// File: rtl/signed_pkg.sv
// rtl/signed_pkg.sv - shared FSM states and saturation bound helpers
package signed_pkg;

  // Frame-level control states of the accumulator
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Largest value representable in a w-bit two's-complement word
  function automatic int SAT_MAX(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's-complement word
  function automatic int SAT_MIN(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/signed_sat_add.sv
// rtl/signed_sat_add.sv - sign-extending adder that clamps to the accumulator range
module signed_sat_add
  import signed_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]     sample,
  output logic [ACC_WIDTH-1:0] sat_sum,
  output logic                 sat_flag
);

  // One guard bit is enough: the sample is always narrower than the accumulator
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(SAT_MAX(ACC_WIDTH));
  localparam logic signed [SW-1:0] MIN_V = SW'(SAT_MIN(ACC_WIDTH));

  logic signed [SW-1:0] sum;

  assign sum = $signed({{(SW - WIDTH){sample[WIDTH-1]}}, sample})
             + $signed({acc[ACC_WIDTH-1], acc});

  // Clamp the wide sum into range and flag whenever a clamp happened
  always_comb begin
    sat_flag = 1'b0;
    sat_sum  = sum[ACC_WIDTH-1:0];
    if (sum > MAX_V) begin
      sat_sum  = ACC_WIDTH'(SAT_MAX(ACC_WIDTH));
      sat_flag = 1'b1;
    end else if (sum < MIN_V) begin
      sat_sum  = ACC_WIDTH'(SAT_MIN(ACC_WIDTH));
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/signed_sat_accumulator.sv
// rtl/signed_sat_accumulator.sv - frames N_SAMPLES signed samples into a saturating sum
module signed_sat_accumulator
  import signed_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int N_SAMPLES = 15,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow,
  output logic [CNT_W-1:0]     sample_cnt
);

  state_t               state;
  logic                 accept;
  logic                 last_sample;
  logic [ACC_WIDTH-1:0] add_acc;
  logic [ACC_WIDTH-1:0] sat_sum;
  logic                 sat_flag;
  logic [CNT_W-1:0]     cnt_next;

  // Input is only back-pressured while a finished result waits for its consumer
  assign in_ready    = (state != S_DONE);
  assign accept      = in_valid & in_ready;
  // A new frame starts from zero so the first sample is just its sign extension
  assign add_acc     = (state == S_IDLE) ? '0 : acc_out;
  assign cnt_next    = sample_cnt + CNT_W'(1);
  assign last_sample = (cnt_next == CNT_W'(N_SAMPLES));

  signed_sat_add #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_add (
    .acc     (add_acc),
    .sample  (in_data),
    .sat_sum (sat_sum),
    .sat_flag(sat_flag)
  );

  // Frame FSM: accumulate accepted samples, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= S_IDLE;
      acc_out    <= '0;
      sample_cnt <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc_out    <= sat_sum;
            sample_cnt <= cnt_next;
            overflow   <= overflow | sat_flag;
            if (last_sample) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state      <= S_IDLE;
            acc_out    <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb/tb_signed_sat_accumulator.sv - randomized and directed bench with a frame-level reference model
module tb_signed_sat_accumulator;

  localparam int N = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] in_data;

  logic       in_ready_a, out_valid_a, overflow_a;
  logic [7:0] acc_a;
  logic [3:0] cnt_a;
  logic       in_ready_b, out_valid_b, overflow_b;
  logic [5:0] acc_b;
  logic [3:0] cnt_b;

  int tests = 0;
  int fails = 0;

  // reference model: frame sums held as plain integers for both accumulator widths
  int m_acc_a, m_acc_b, m_cnt;
  bit m_done, m_ovf_a, m_ovf_b;

  always #5 clk = ~clk;

  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .N_SAMPLES(N), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .acc_out(acc_a), .overflow(overflow_a), .sample_cnt(cnt_a)
  );

  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .N_SAMPLES(N), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .acc_out(acc_b), .overflow(overflow_b), .sample_cnt(cnt_b)
  );

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    if (observed != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_zero();
    m_acc_a = 0; m_acc_b = 0; m_cnt = 0; m_done = 0; m_ovf_a = 0; m_ovf_b = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".in_ready_a"},  int'(in_ready_a),  int'(!m_done));
    check({tag, ".in_ready_b"},  int'(in_ready_b),  int'(!m_done));
    check({tag, ".out_valid_a"}, int'(out_valid_a), int'(m_done));
    check({tag, ".out_valid_b"}, int'(out_valid_b), int'(m_done));
    check({tag, ".acc_a"},       int'($signed(acc_a)), m_acc_a);
    check({tag, ".acc_b"},       int'($signed(acc_b)), m_acc_b);
    check({tag, ".ovf_a"},       int'(overflow_a), int'(m_ovf_a));
    check({tag, ".ovf_b"},       int'(overflow_b), int'(m_ovf_b));
    check({tag, ".cnt_a"},       int'(cnt_a), m_cnt);
    check({tag, ".cnt_b"},       int'(cnt_b), m_cnt);
  endtask

  // apply one cycle of inputs, advance the model with the same inputs, then compare
  task automatic cycle(input string tag, input bit r, input bit c, input bit v,
                       input logic [3:0] d, input bit ordy);
    int s, ra, rb;
    rst = r; clear = c; in_valid = v; in_data = d; out_ready = ordy;
    @(posedge clk);
    if (r || c) begin
      model_zero();
    end else if (m_done) begin
      if (ordy) model_zero();
    end else if (v) begin
      s  = int'($signed(d));
      ra = m_acc_a + s;
      rb = m_acc_b + s;
      m_acc_a = clamp(ra, -128, 127);
      m_acc_b = clamp(rb, -32, 31);
      if (m_acc_a != ra) m_ovf_a = 1;
      if (m_acc_b != rb) m_ovf_b = 1;
      m_cnt++;
      if (m_cnt == N) m_done = 1;
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [7:0] held_acc;
    rst = 1; clear = 0; in_valid = 1; in_data = 4'h5; out_ready = 1;
    model_zero();

    // reset held 3 cycles with valid input present
    for (int i = 0; i < 3; i++) cycle("reset", 1, 0, 1, 4'($urandom), 1);
    check("reset.acc_const", int'(acc_a), 0);
    check("reset.ovalid_const", int'(out_valid_a), 0);

    // 15 samples of +1
    for (int i = 0; i < N; i++) cycle("ones", 0, 0, 1, 4'h1, 1);
    check("ones.result", int'(acc_a), 8'h0F);
    check("ones.valid", int'(out_valid_a), 1);
    cycle("ones.hs", 0, 0, 0, 4'h0, 1);

    // alternate -8 / +7 starting with -8
    for (int i = 0; i < N; i++) cycle("alt", 0, 0, 1, (i % 2 == 0) ? 4'h8 : 4'h7, 1);
    check("alt.result", int'(acc_a), 8'hF1);
    check("alt.ovf", int'(overflow_a), 0);
    cycle("alt.hs", 0, 0, 0, 4'h0, 1);

    // 15 samples of +7: narrow instance saturates at 31
    for (int i = 0; i < N; i++) cycle("sat", 0, 0, 1, 4'h7, 1);
    check("sat.narrow_result", int'(acc_b), 6'h1F);
    check("sat.narrow_ovf", int'(overflow_b), 1);
    check("sat.wide_result", int'(acc_a), 105);
    cycle("sat.hs", 0, 0, 1, 4'h7, 1);
    check("sat.ovf_cleared", int'(overflow_b), 0);
    cycle("sat.after", 0, 0, 0, 4'h0, 1);

    // back-pressure in DONE: input ignored, result stable
    for (int i = 0; i < N; i++) cycle("bp.fill", 0, 0, 1, 4'h3, 0);
    held_acc = acc_a;
    for (int i = 0; i < 5; i++) begin
      cycle("bp.hold", 0, 0, 1, 4'h1, 0);
      check("bp.acc_stable", int'(acc_a), int'(held_acc));
      check("bp.in_ready", int'(in_ready_a), 0);
    end
    cycle("bp.hs", 0, 0, 1, 4'h1, 1);
    cycle("bp.after", 0, 0, 0, 4'h0, 1);

    // abort mid-frame with clear, then with rst
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 7; i++) cycle("abort.fill", 0, 0, 1, 4'h2, 1);
      cycle("abort.cycle", k == 1, k == 0, 1, 4'h2, 1);
      check("abort.acc_zero", int'(acc_a), 0);
      check("abort.cnt_zero", int'(cnt_a), 0);
      for (int i = 0; i < N; i++) cycle("abort.refill", 0, 0, 1, 4'h1, 1);
      check("abort.result", int'(acc_a), 8'h0F);
      cycle("abort.hs", 0, 0, 0, 4'h0, 1);
    end

    // randomized traffic with occasional clear/reset and random back-pressure
    for (int i = 0; i < 4000; i++) begin
      cycle("rand",
            $urandom_range(0, 299) == 0,
            $urandom_range(0, 149) == 0,
            $urandom_range(0, 9) < 7,
            4'($urandom),
            $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
